branch_redirect_unit: RTL

BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

---
 rtl/branch_redirect_unit_pkg.sv | 24 ++
 rtl/sat_counter.sv | 37 +++
 rtl/branch_redirect_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/branch_redirect_unit_pkg.sv
// ============================================================================
// Module      : branch_redirect_unit_pkg
// Description : Shared word width and branch-command encodings for the
//               ID-stage branch redirect logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_redirect_unit_pkg;

    localparam int WORD_LEN = 32;

    localparam logic [1:0] COND_NONE = 2'b00;
    localparam logic [1:0] COND_JUMP = 2'b01;
    localparam logic [1:0] COND_BEZ  = 2'b10;
    localparam logic [1:0] COND_BNE  = 2'b11;

    function automatic logic isCondBranch(input logic [1:0] comm);
        return (comm == COND_BEZ) || (comm == COND_BNE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with a synchronous clear that takes
//               priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/branch_redirect_unit.sv
// ============================================================================
// Module      : branch_redirect_unit
// Description : Zero-latency PC redirect and IF/ID flush for taken branches
//               resolved in ID, with branch statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                brCond,
    input  logic [1:0]          cuBranchComm,
    input  logic [WORD_LEN-1:0] branchAddr,
    input  logic                idValid,
    input  logic                hazardStall,
    input  logic                clrCnt,
    output logic                pcSrc,
    output logic [WORD_LEN-1:0] pcTarget,
    output logic                flushIFID,
    output logic [CNT_W-1:0]    jumpCnt,
    output logic [CNT_W-1:0]    takenCnt,
    output logic [CNT_W-1:0]    notTakenCnt
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SQUASH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_nextState;
    logic   w_decision;
    logic   w_redirect;
    logic   w_incJump;
    logic   w_incTaken;
    logic   w_incNotTaken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // SQUASH covers the wrong-path slot sitting in ID after a redirect; it
    // only drains once the pipeline actually advances.
    always_comb begin
        w_nextState = r_state;
        w_decision  = 1'b0;
        w_redirect  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_decision = idValid && !hazardStall && (cuBranchComm != COND_NONE);
                w_redirect = w_decision && brCond && rst;
                if (w_decision && brCond) begin
                    w_nextState = S_SQUASH;
                end
            end
            S_SQUASH: begin
                if (!hazardStall) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign pcSrc     = w_redirect;
    assign flushIFID = w_redirect;
    assign pcTarget  = w_redirect ? branchAddr : '0;

    assign w_incJump     = w_decision && (cuBranchComm == COND_JUMP);
    assign w_incTaken    = w_decision && isCondBranch(cuBranchComm) && brCond;
    assign w_incNotTaken = w_decision && isCondBranch(cuBranchComm) && !brCond;

    sat_counter #(.CNT_W(CNT_W)) u_jumpCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_incJump),
        .clr   (clrCnt),
        .count (jumpCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_takenCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_incTaken),
        .clr   (clrCnt),
        .count (takenCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_notTakenCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_incNotTaken),
        .clr   (clrCnt),
        .count (notTakenCnt)
    );

endmodule

`default_nettype wire
